data_ram_pipelined: RTL and testbench

Parametrised data-memory slave on the Ibex data bus: single-port word RAM with configurable size, base address, and read latency. It answers out-of-range accesses with a bus error, and accepts one request per cycle with fully pipelined responses. It sits between the core's data bus and the SoC memory map, replacing the fixed 1-cycle data RAM.

---
 rtl/soc_mem_pkg.sv | 13 +
 rtl/ibex_data_bus.sv | 14 +
 rtl/data_ram_rsp_pipe.sv | 35 +++
 rtl/ram.sv | 24 ++
 rtl/data_ram_pipelined.sv | 56 +++++
 tb/tb_data_ram_pipelined.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types and helpers for SoC memory slaves
package soc_mem_pkg;
  localparam int MAX_LATENCY = 4;
  typedef struct packed {
    logic valid;
    logic err;
    logic is_read;
  } mem_rsp_t;
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned depth_words);
    return (addr - base) < 32'(depth_words * 4);
  endfunction
endpackage

// File: rtl/ibex_data_bus.sv
// ibex_data_bus: Ibex data bus request/response signals
interface ibex_data_bus;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;
  modport master (output req, we, be, addr, wdata, input gnt, rvalid, err, rdata);
  modport slave (input req, we, be, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/data_ram_rsp_pipe.sv
// data_ram_rsp_pipe: response shift register with RAM read data staging
module data_ram_rsp_pipe
  import soc_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  mem_rsp_t    rsp_in,
  input  logic [31:0] ram_rdata,
  output logic        rvalid,
  output logic        err,
  output logic [31:0] rdata
);
  for (genvar g = 0; g < LATENCY; g++) begin : g_st
    mem_rsp_t    r;
    logic [31:0] d;
    if (g == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= '0;
        else r <= rsp_in;
      // the RAM output register already is the first data stage
      assign d = ram_rdata;
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= '0;
        else r <= g_st[g-1].r;
      always_ff @(posedge clk) d <= g_st[g-1].d;
    end
  end
  assign rvalid = g_st[LATENCY-1].r.valid;
  assign err    = g_st[LATENCY-1].r.valid & g_st[LATENCY-1].r.err;
  assign rdata  = (g_st[LATENCY-1].r.valid & g_st[LATENCY-1].r.is_read & ~g_st[LATENCY-1].r.err)
                  ? g_st[LATENCY-1].d : 32'h0;
endmodule

// File: rtl/ram.sv
// ram: single-port word RAM, 1-cycle synchronous read, byte write enables
module ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
endmodule

// File: rtl/data_ram_pipelined.sv
// data_ram_pipelined: Ibex data-bus RAM slave with range check and configurable read latency
module data_ram_pipelined
  import soc_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  ibex_data_bus.slave data_bus,
  output logic [7:0] err_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("LATENCY must be within 1..MAX_LATENCY");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two");
  end
  if ((BASE_ADDR % (DEPTH_WORDS * 4)) != 0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to the RAM size");
  end
  logic          acc;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   ram_rdata;
  mem_rsp_t      rsp;
  assign data_bus.gnt = data_bus.req;
  // grants seen while in reset are ignored entirely
  assign acc      = data_bus.req & rst_n;
  assign in_range = addr_in_range(data_bus.addr, BASE_ADDR, DEPTH_WORDS);
  assign idx      = AW'((data_bus.addr - BASE_ADDR) >> 2);
  assign rsp      = '{valid: acc, err: acc & ~in_range, is_read: ~data_bus.we};
  ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (acc & in_range),
    .we    (data_bus.we),
    .be    (data_bus.be),
    .addr  (idx),
    .wdata (data_bus.wdata),
    .rdata (ram_rdata)
  );
  data_ram_rsp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsp_in    (rsp),
    .ram_rdata (ram_rdata),
    .rvalid    (data_bus.rvalid),
    .err       (data_bus.err),
    .rdata     (data_bus.rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= 8'h00;
    else if (data_bus.rvalid && data_bus.err && err_count != 8'hFF) err_count <= err_count + 8'd1;
endmodule

// File: tb/tb_data_ram_pipelined.sv
// tb_data_ram_pipelined: scoreboard bench driving LATENCY 1..4 instances with one shared stimulus
module tb_data_ram_pipelined;
  localparam int          DW   = 64;
  localparam logic [31:0] BASE = 32'h0001_0000;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          g;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          n_err = 0;
  int          epoch = 0;
  exp_t        hist[$];
  logic [31:0] mem [DW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ibex_data_bus bus ();
    logic [7:0] ec;
    int         rp = 0;
    assign bus.req   = req;
    assign bus.we    = we;
    assign bus.be    = be;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;
    data_ram_pipelined #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE), .LATENCY(k + 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_bus  (bus),
      .err_count (ec)
    );
    always @(negedge clk) begin
      exp_t e;
      n_chk++;
      if (bus.gnt !== req) begin
        n_bad++;
        $display("FAIL gnt L=%0d got %b want %b", k + 1, bus.gnt, req);
      end
      if (rp < epoch) rp = epoch;
      n_chk++;
      if (bus.rvalid === 1'b1) begin
        if (rp >= hist.size()) begin
          n_bad++;
          $display("FAIL spurious_rvalid L=%0d cyc=%0d", k + 1, cyc);
        end else begin
          e = hist[rp];
          rp++;
          if (bus.err !== e.err || bus.rdata !== e.rdata || cyc != e.g + k) begin
            n_bad++;
            $display("FAIL rsp L=%0d got err=%b rdata=%h cyc=%0d want err=%b rdata=%h cyc=%0d",
                     k + 1, bus.err, bus.rdata, cyc, e.err, e.rdata, e.g + k);
          end
        end
      end else if (bus.rvalid !== 1'b0 || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL idle L=%0d got rvalid=%b err=%b want 0 0", k + 1, bus.rvalid, bus.err);
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] off;
    int          idx;
    @(posedge clk);
    #1;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    off     = a - BASE;
    e.g     = cyc + 1;
    e.err   = off >= 32'(DW * 4);
    e.rdata = 32'h0;
    if (e.err) begin
      n_err = (n_err < 255) ? n_err + 1 : 255;
    end else begin
      idx = int'(off / 4);
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.rdata = mem[idx];
      end
    end
    hist.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic check_ec(input int k, input logic [7:0] act);
    n_chk++;
    if (act !== 8'(n_err)) begin
      n_bad++;
      $display("FAIL err_count L=%0d got %0d want %0d", k, act, n_err);
    end
  endtask

  task automatic check_all_ec();
    check_ec(1, g_dut[0].ec);
    check_ec(2, g_dut[1].ec);
    check_ec(3, g_dut[2].ec);
    check_ec(4, g_dut[3].ec);
  endtask

  task automatic drain();
    int t = 0;
    idle();
    while (!(g_dut[0].rp == hist.size() && g_dut[1].rp == hist.size() &&
             g_dut[2].rp == hist.size() && g_dut[3].rp == hist.size()) && t < 20) begin
      @(posedge clk);
      t++;
    end
    n_chk++;
    if (t >= 20) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", hist.size() - g_dut[0].rp);
    end
    repeat (2) @(posedge clk);
    #1 check_all_ec();
  endtask

  // reset with req held high on a write: that write must not land
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    epoch = hist.size();
    n_err = 0;
    req = 1'b1; we = 1'b1; be = 4'hF; addr = BASE + 32'd20; wdata = ~mem[5];
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    rst_n = 1'b1;
    check_all_ec();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all_ec();
    for (int i = 0; i < DW; i++) issue(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
    drain();
    issue(1'b1, 4'hF, BASE + 32'd8, 32'hDEAD_BEEF);
    issue(1'b0, 4'hF, BASE + 32'd8, 32'h0);
    issue(1'b1, 4'hF, BASE + 32'd12, 32'h1122_3344);
    issue(1'b1, 4'b0101, BASE + 32'd13, 32'hAABB_CCDD);
    issue(1'b0, 4'h0, BASE + 32'd12, 32'h0);
    issue(1'b1, 4'h0, BASE + 32'd12, 32'hFFFF_FFFF);
    issue(1'b0, 4'hF, BASE + 32'd12, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b1, 4'hF, BASE + 32'(40 + 4 * i), 32'(i + 1));
    for (int i = 0; i < 4; i++) issue(1'b0, 4'hF, BASE + 32'(40 + 4 * i), 32'h0);
    issue(1'b1, 4'hF, BASE + 32'd100, 32'h5A5A_A5A5);
    issue(1'b0, 4'hF, BASE + 32'd100, 32'h0);
    drain();
    issue(1'b0, 4'hF, BASE + 32'(DW * 4), 32'h0);
    issue(1'b1, 4'hF, BASE - 32'd4, 32'hCAFE_F00D);
    issue(1'b0, 4'hF, BASE, 32'h0);
    issue(1'b0, 4'hF, BASE + 32'(DW * 4 - 4), 32'h0);
    drain();
    repeat (400) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = BASE + 32'($urandom_range(0, DW * 4 - 1));
      if (r < 15) idle();
      else begin
        if (r < 30) a = r[0] ? BASE + 32'(DW * 4) + ($urandom % 1024) : BASE - 32'd1 - ($urandom % 1024);
        issue(r[1], 4'($urandom), a, $urandom);
      end
    end
    drain();
    for (int i = 0; i < 300; i++) issue(i[0], 4'hF, BASE + 32'h0010_0000 + 32'(4 * i), $urandom);
    drain();
    for (int i = 0; i < 3; i++) issue(1'b0, 4'hF, BASE + 32'(4 * (5 + i)), 32'h0);
    pulse_reset();
    issue(1'b0, 4'hF, BASE + 32'd20, 32'h0);
    issue(1'b0, 4'hF, BASE + 32'd8, 32'h0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
